// File: rtl/hwpe_ctrl_ctx_scheduler.sv
// Job-context scheduler: test-and-set acquire, trigger commit, FIFO engine start and
// per-core completion events over a ring of N_CONTEXT job contexts.
module hwpe_ctrl_ctx_scheduler #(
   parameter int unsigned N_CONTEXT = 2,
   parameter int unsigned N_CORES   = 8,
   parameter int unsigned CTX_W     = $clog2(N_CONTEXT),
   parameter int unsigned CORE_W    = $clog2(N_CORES)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              acquire_req_i,
   input  logic [CORE_W-1:0] acquire_core_i,
   output logic              acquire_gnt_o,
   output logic [CTX_W-1:0]  acquire_ctx_o,
   input  logic              trigger_i,
   output logic              err_o,
   output logic              start_o,
   input  logic              done_i,
   output logic [CTX_W-1:0]  running_ctx_o,
   output logic [CTX_W-1:0]  pointer_ctx_o,
   output logic              is_working_o,
   output logic [N_CORES-1:0] evt_o,
   output logic [CTX_W:0]    nb_free_o
);

   typedef enum logic [1:0] {CtxFree, CtxAcquired, CtxQueued, CtxRunning} ctx_state_e;
   typedef enum logic [1:0] {StIdle, StStart, StRun, StFinish} fsm_state_e;

   ctx_state_e        ctx_q   [N_CONTEXT];
   ctx_state_e        ctx_d   [N_CONTEXT];
   logic [CORE_W-1:0] owner_q [N_CONTEXT];
   logic [CORE_W-1:0] owner_d [N_CONTEXT];

   fsm_state_e        fsm_q, fsm_d;
   logic [CTX_W-1:0]  pointer_q, pointer_d;
   logic [CTX_W-1:0]  running_q, running_d;
   logic [CTX_W:0]    nb_free_q, nb_free_d;
   logic              lock_q, lock_d;
   logic              start_q, start_d;
   logic              err_q, err_d;
   logic [N_CORES-1:0] evt_q, evt_d;

   logic              gnt;
   logic              trig_ok;
   logic              fin;
   logic [CTX_W-1:0]  acq_idx;
   logic [CTX_W-1:0]  next_run;

   assign gnt      = acquire_req_i & ~lock_q & (nb_free_q != '0);
   assign trig_ok  = trigger_i & lock_q;
   // Only one context can be ACQUIRED: the one just behind the allocation pointer.
   assign acq_idx  = pointer_q - CTX_W'(1);
   assign next_run = running_q + CTX_W'(1);
   assign fin      = (fsm_q == StFinish);

   always_comb begin
      ctx_d     = ctx_q;
      owner_d   = owner_q;
      fsm_d     = fsm_q;
      pointer_d = pointer_q;
      running_d = running_q;
      lock_d    = lock_q;
      start_d   = 1'b0;
      evt_d     = '0;
      err_d     = trigger_i & ~lock_q;
      nb_free_d = nb_free_q - {{CTX_W{1'b0}}, gnt} + {{CTX_W{1'b0}}, fin};

      // Grant and valid trigger are mutually exclusive since both depend on lock_q.
      if (gnt) begin
         ctx_d[pointer_q]   = CtxAcquired;
         owner_d[pointer_q] = acquire_core_i;
         lock_d             = 1'b1;
         pointer_d          = pointer_q + CTX_W'(1);
      end else if (trig_ok) begin
         ctx_d[acq_idx] = CtxQueued;
         lock_d         = 1'b0;
      end

      unique case (fsm_q)
         StIdle: begin
            if (ctx_q[running_q] == CtxQueued) begin
               fsm_d   = StStart;
               start_d = 1'b1;
            end
         end
         StStart: begin
            ctx_d[running_q] = CtxRunning;
            fsm_d            = StRun;
         end
         StRun: begin
            if (done_i) begin
               fsm_d                   = StFinish;
               evt_d[owner_q[running_q]] = 1'b1;
            end
         end
         StFinish: begin
            ctx_d[running_q] = CtxFree;
            running_d        = next_run;
            if (ctx_q[next_run] == CtxQueued) begin
               fsm_d   = StStart;
               start_d = 1'b1;
            end else begin
               fsm_d = StIdle;
            end
         end
         default: fsm_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < N_CONTEXT; i++) begin
            ctx_q[i]   <= CtxFree;
            owner_q[i] <= '0;
         end
         fsm_q     <= StIdle;
         pointer_q <= '0;
         running_q <= '0;
         nb_free_q <= (CTX_W+1)'(N_CONTEXT);
         lock_q    <= 1'b0;
         start_q   <= 1'b0;
         err_q     <= 1'b0;
         evt_q     <= '0;
      end else if (clear_i) begin
         for (int unsigned i = 0; i < N_CONTEXT; i++) begin
            ctx_q[i]   <= CtxFree;
            owner_q[i] <= '0;
         end
         fsm_q     <= StIdle;
         pointer_q <= '0;
         running_q <= '0;
         nb_free_q <= (CTX_W+1)'(N_CONTEXT);
         lock_q    <= 1'b0;
         start_q   <= 1'b0;
         err_q     <= 1'b0;
         evt_q     <= '0;
      end else begin
         ctx_q     <= ctx_d;
         owner_q   <= owner_d;
         fsm_q     <= fsm_d;
         pointer_q <= pointer_d;
         running_q <= running_d;
         nb_free_q <= nb_free_d;
         lock_q    <= lock_d;
         start_q   <= start_d;
         err_q     <= err_d;
         evt_q     <= evt_d;
      end
   end

   assign acquire_gnt_o = gnt;
   assign acquire_ctx_o = pointer_q;
   assign pointer_ctx_o = pointer_q;
   assign running_ctx_o = running_q;
   assign nb_free_o     = nb_free_q;
   assign start_o       = start_q;
   assign err_o         = err_q;
   assign evt_o         = evt_q;
   assign is_working_o  = (fsm_q == StStart) || (fsm_q == StRun);

`ifndef SYNTHESIS
   logic [N_CONTEXT-1:0] acq_mask;
   always_comb begin
      acq_mask = '0;
      for (int unsigned i = 0; i < N_CONTEXT; i++) acq_mask[i] = (ctx_q[i] == CtxAcquired);
   end

   a_nb_free_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      nb_free_q <= (CTX_W+1)'(N_CONTEXT));
   a_single_acquired: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $countones(acq_mask) <= 1);
   a_start_evt_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(start_q && (evt_q != '0)));
`endif

endmodule

// File: tb/tb_hwpe_ctrl_ctx_scheduler.sv
// Bench for hwpe_ctrl_ctx_scheduler: directed scenarios plus randomized traffic, all
// checked every cycle against a job-queue model with timing rules taken from the contract.
module tb_hwpe_ctrl_ctx_scheduler;

   localparam int NC    = 2;
   localparam int NCORE = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear, acq_req, trig, done;
   logic [2:0] acq_core;
   logic       gnt, err, start, working;
   logic [0:0] actx, running, pointer;
   logic [7:0] evt;
   logic [1:0] nb_free;

   hwpe_ctrl_ctx_scheduler #(.N_CONTEXT(NC), .N_CORES(NCORE)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .clear_i        (clear),
      .acquire_req_i  (acq_req),
      .acquire_core_i (acq_core),
      .acquire_gnt_o  (gnt),
      .acquire_ctx_o  (actx),
      .trigger_i      (trig),
      .err_o          (err),
      .start_o        (start),
      .done_i         (done),
      .running_ctx_o  (running),
      .pointer_ctx_o  (pointer),
      .is_working_o   (working),
      .evt_o          (evt),
      .nb_free_o      (nb_free)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Model state: counts and a FIFO of committed jobs, with an engine slot.
   int m_free, m_lock, m_ptr, m_run, m_err, m_start, m_evt, m_working;
   int acq_owner;
   int jobq[$];
   int jobq_t[$];
   int eng_job, eng_owner, eng_s, last_evt;

   task automatic cmp(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_free = NC; m_lock = 0; m_ptr = 0; m_run = 0;
      m_err = 0; m_start = 0; m_evt = -1; m_working = 0;
      acq_owner = 0; jobq.delete(); jobq_t.delete();
      eng_job = 0; eng_owner = 0; eng_s = 0; last_evt = -100;
   endtask

   task automatic check_model(input bit req);
      int exp_evt;
      exp_evt = (m_evt >= 0) ? (1 << m_evt) : 0;
      cmp("gnt", gnt, (req && !m_lock && m_free > 0) ? 1 : 0);
      cmp("acquire_ctx", actx, m_ptr);
      cmp("pointer_ctx", pointer, m_ptr);
      cmp("running_ctx", running, m_run);
      cmp("nb_free", nb_free, m_free);
      cmp("err", err, m_err);
      cmp("start", start, m_start);
      cmp("is_working", working, m_working);
      cmp("evt", evt, exp_evt);
   endtask

   task automatic model_step(input bit req, input int core, input bit tr, input bit dn,
                             input bit cl);
      int g, n_evt;
      if (cl) begin
         model_reset();
         return;
      end
      g = (req && !m_lock && m_free > 0) ? 1 : 0;
      m_err = (tr && !m_lock) ? 1 : 0;
      // A context is freed in the cycle after its completion event shows.
      if (m_evt >= 0) begin
         m_free = m_free + 1;
         m_run  = (m_run + 1) % NC;
      end
      if (g == 1) begin
         m_free    = m_free - 1;
         m_ptr     = (m_ptr + 1) % NC;
         m_lock    = 1;
         acq_owner = core;
      end else if (tr && m_lock) begin
         jobq.push_back(acq_owner);
         jobq_t.push_back(cyc);
         m_lock = 0;
      end
      n_evt = -1;
      if (eng_job && dn && cyc > eng_s) begin
         n_evt    = eng_owner;
         eng_job  = 0;
         last_evt = cyc + 1;
      end
      m_start = 0;
      // Start = max(commit + 2, previous event + 1), strictly in commit order.
      if (!eng_job && jobq.size() > 0 && cyc + 1 >= jobq_t[0] + 2 && cyc + 1 >= last_evt + 1)
      begin
         eng_job   = 1;
         eng_owner = jobq.pop_front();
         void'(jobq_t.pop_front());
         eng_s     = cyc + 1;
         m_start   = 1;
      end
      m_evt     = n_evt;
      m_working = eng_job;
   endtask

   task automatic step(input bit req, input int core, input bit tr, input bit dn,
                       input bit cl);
      @(negedge clk);
      acq_req  = req;
      acq_core = 3'(core);
      trig     = tr;
      done     = dn;
      clear    = cl;
      #1;
      check_model(req);
      model_step(req, core, tr, dn, cl);
      cyc++;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0; clear = 0; acq_req = 0; trig = 0; done = 0; acq_core = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      cmp("reset_nb_free", nb_free, 2);
      cmp("reset_pointer", pointer, 0);
      cmp("reset_running", running, 0);
      cmp("reset_working", working, 0);
      cmp("reset_evt", evt, 0);
      cmp("reset_start", start, 0);

      // Single job from core 3.
      step(1, 3, 0, 0, 0); cmp("sj_gnt", gnt, 1); cmp("sj_ctx", actx, 0);
      step(0, 0, 1, 0, 0);
      idle();              cmp("sj_start_t1", start, 0);
      idle();              cmp("sj_start_t2", start, 1); cmp("sj_running", running, 0);
      step(0, 0, 0, 1, 0);
      idle();              cmp("sj_evt", evt, 8'h08);
      idle();              cmp("sj_nb_free", nb_free, 2);

      // Ring full, wrap-around and back-to-back.
      step(0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(1, 2, 0, 0, 0); cmp("rf_gnt2", gnt, 1);
      step(0, 0, 1, 0, 0); cmp("rf_start1", start, 1);
      step(1, 4, 0, 0, 0); cmp("rf_gnt_full", gnt, 0); cmp("rf_nb_free0", nb_free, 0);
      step(0, 0, 0, 1, 0);
      idle();              cmp("rf_evt_core1", evt, 8'h02);
      step(1, 4, 0, 0, 0); cmp("rf_b2b_start", start, 1); cmp("rf_wrap_gnt", gnt, 1);
                           cmp("rf_wrap_ctx", actx, 0);
      step(0, 0, 0, 1, 0);
      idle();              cmp("rf_evt_core2", evt, 8'h04);
      step(0, 0, 1, 0, 0);
      repeat (2) idle();
      step(0, 0, 0, 1, 0);
      repeat (2) idle();

      // Lock behaviour.
      step(0, 0, 0, 0, 1);
      step(1, 5, 0, 0, 0); cmp("lk_gnt1", gnt, 1);
      step(1, 6, 0, 0, 0); cmp("lk_gnt_locked", gnt, 0);
      step(1, 6, 1, 0, 0); cmp("lk_gnt_trig_same", gnt, 0);
      step(1, 6, 0, 0, 0); cmp("lk_gnt_after", gnt, 1);
      step(0, 0, 1, 0, 0);
      repeat (10) step(0, 0, 0, 1, 0);

      // Error trigger and stray done.
      step(0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0);
      idle();              cmp("er_err", err, 1); cmp("er_nb_free", nb_free, 2);
      step(0, 0, 0, 1, 0); cmp("er_err_clear", err, 0);
      idle();              cmp("er_no_evt", evt, 0);

      // Synchronous clear while running.
      step(1, 2, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      repeat (3) idle();   cmp("cl_working", working, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0);
      idle();              cmp("cl_no_evt", evt, 0); cmp("cl_nb_free", nb_free, 2);
                           cmp("cl_pointer", pointer, 0); cmp("cl_running", running, 0);

      // Asynchronous reset mid-cycle while running.
      step(1, 2, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      repeat (3) idle();   cmp("ar_working", working, 1);
      @(negedge clk);
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      cmp("ar_working_off", working, 0);
      cmp("ar_nb_free", nb_free, 2);
      cmp("ar_pointer", pointer, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 1, 0);
      idle();              cmp("ar_no_evt", evt, 0); cmp("ar_running", running, 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 3) == 0, int'($urandom % NCORE), ($urandom % 4) == 0,
              ($urandom % 3) == 0, ($urandom % 300) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
